// File: rtl/melody_seq_if.sv
// Control, status and note-ROM bus of one melody sequencer.
// The master side owns start/stop/song_sel and the ROM; the slave is melody_seq.
interface melody_seq_if;
    logic       start;
    logic       stop;
    logic [1:0] song_sel;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic       tone;
    logic       busy;
    logic [3:0] step;
    logic       done;

    modport master (
        output start, stop, song_sel, rom_data,
        input  rom_addr, tone, busy, step, done
    );

    modport slave (
        input  start, stop, song_sel, rom_data,
        output rom_addr, tone, busy, step, done
    );
endinterface

// File: rtl/melody_seq.sv
// Melody sequencer: walks up to 16 note words of one song in an external
// asynchronous ROM, plays each as a square wave for (dur+1) beats, inserts a
// silent gap, and pulses done at the natural end of the song.
module melody_seq #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BEAT_CYCLES = 6250000,
    parameter int unsigned GAP_CYCLES  = 250000,
    parameter bit          LOOP        = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    melody_seq_if.slave bus_io
);

    // Half-period in clk cycles of note code n (1..24 = C4..B5, A4 = 10).
    // Other codes never toggle, so they just get a harmless 1.
    function automatic int unsigned half_of(int unsigned n);
        real         ratio;
        real         freq;
        int unsigned m;
        int unsigned h;
        if (n < 1 || n > 24) return 1;
        // m counts semitones above A3 (220 Hz); A4 lands on m = 12.
        m = n + 2;
        case (m % 12)
            0:       ratio = 1.0;
            1:       ratio = 1.0594630943592953;
            2:       ratio = 1.122462048309373;
            3:       ratio = 1.189207115002721;
            4:       ratio = 1.2599210498948732;
            5:       ratio = 1.3348398541700344;
            6:       ratio = 1.4142135623730951;
            7:       ratio = 1.4983070768766815;
            8:       ratio = 1.5874010519681994;
            9:       ratio = 1.681792830507429;
            10:      ratio = 1.7817974362806785;
            default: ratio = 1.8877486253633868;
        endcase
        freq = 220.0 * ratio;
        if (m >= 12) freq = freq * 2.0;
        if (m >= 24) freq = freq * 2.0;
        h = $rtoi(real'(CLK_HZ) / (2.0 * freq) + 0.5);
        return (h < 1) ? 1 : h;
    endfunction

    // C4 has the longest half-period, so it sizes the half-period counter.
    localparam int unsigned HalfW = $clog2(half_of(1) + 1);
    localparam int unsigned BeatW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StPlay, StGap, StAdv, StDone} state_e;

    state_e             state_q;
    logic [1:0]         song_q;
    logic [3:0]         step_q;
    logic               pitched_q;
    logic [HalfW-1:0]   half_q;
    logic [HalfW-1:0]   half_cnt_q;
    logic [BeatW-1:0]   beat_cnt_q;
    logic [2:0]         beats_left_q;
    logic [GapW-1:0]    gap_cnt_q;
    logic               tone_q;
    logic               busy_q;
    logic               done_q;

    logic [HalfW-1:0]   half_tbl [32];
    logic [4:0]         rom_note;
    logic [2:0]         rom_dur;
    logic               rom_pitched;
    logic               beat_wrap;
    logic               play_last;
    logic               half_wrap;
    logic               gap_last;

    for (genvar g = 0; g < 32; g++) begin : g_half
        assign half_tbl[g] = HalfW'(half_of(g));
    end

    assign rom_note    = bus_io.rom_data[7:3];
    assign rom_dur     = bus_io.rom_data[2:0];
    assign rom_pitched = (rom_note != 5'd0) && (rom_note <= 5'd24);
    assign beat_wrap   = (beat_cnt_q == BeatW'(BEAT_CYCLES - 1));
    assign play_last   = beat_wrap && (beats_left_q == 3'd0);
    assign half_wrap   = (half_cnt_q == (half_q - HalfW'(1)));
    assign gap_last    = (gap_cnt_q == GapW'(GAP_CYCLES - 1));

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            song_q       <= 2'd0;
            step_q       <= 4'd0;
            pitched_q    <= 1'b0;
            half_q       <= '0;
            half_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            beats_left_q <= 3'd0;
            gap_cnt_q    <= '0;
            tone_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else if (bus_io.stop) begin
            // Abort leaves step where it was and never reports done.
            state_q <= StIdle;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        song_q  <= bus_io.song_sel;
                        step_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    tone_q <= 1'b0;
                    if (rom_note == 5'd31) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        pitched_q    <= rom_pitched;
                        half_q       <= half_tbl[rom_note];
                        beats_left_q <= rom_dur;
                        half_cnt_q   <= '0;
                        beat_cnt_q   <= '0;
                        state_q      <= StPlay;
                    end
                end
                StPlay: begin
                    if (play_last) begin
                        tone_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= StAdv;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= StGap;
                        end
                    end else begin
                        if (beat_wrap) begin
                            beat_cnt_q   <= '0;
                            beats_left_q <= beats_left_q - 3'd1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BeatW'(1);
                        end
                        if (pitched_q) begin
                            if (half_wrap) begin
                                half_cnt_q <= '0;
                                tone_q     <= ~tone_q;
                            end else begin
                                half_cnt_q <= half_cnt_q + HalfW'(1);
                            end
                        end
                    end
                end
                StGap: begin
                    if (gap_last) begin
                        state_q <= StAdv;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end
                StAdv: begin
                    if (step_q != 4'd15) begin
                        step_q  <= step_q + 4'd1;
                        state_q <= StLoad;
                    end else if (LOOP) begin
                        step_q  <= 4'd0;
                        state_q <= StLoad;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    tone_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.rom_addr = {song_q, step_q};
    assign bus_io.tone     = tone_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.step     = step_q;
    assign bus_io.done     = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Bench for melody_seq: a song-schedule model checked every cycle, plus
// hand-computed timing literals for each directed scenario.
module tb_melody_seq;

    localparam int Beat = 1000;
    localparam int Gap  = 2;

    logic clk;
    logic rst_n;
    logic [7:0] rom [64];

    int tests = 0;
    int fails = 0;
    int m_done_cnt = 0;
    int l_done_cnt = 0;

    melody_seq_if m_if ();
    melody_seq_if l_if ();

    melody_seq #(
        .CLK_HZ(88000), .BEAT_CYCLES(Beat), .GAP_CYCLES(Gap), .LOOP(1'b0)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus_io(m_if)
    );

    melody_seq #(
        .CLK_HZ(88000), .BEAT_CYCLES(Beat), .GAP_CYCLES(Gap), .LOOP(1'b1)
    ) u_loop (
        .clk(clk), .rst_n(rst_n), .bus_io(l_if)
    );

    assign m_if.rom_data = rom[m_if.rom_addr];
    assign l_if.rom_data = rom[l_if.rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event not seen within cycle budget (t=%0t)", name, $time);
    endtask

    // Half-period straight from the pitch formula.
    function automatic int half_model(input int n);
        real f;
        f = 440.0 * (2.0 ** ((real'(n) - 10.0) / 12.0));
        return $rtoi(88000.0 / (2.0 * f) + 0.5);
    endfunction

    // ---------------- song-schedule model ----------------
    typedef enum int {SkLoad, SkPlay, SkGap, SkAdv, SkDone} seg_kind_e;
    typedef struct {
        seg_kind_e kind;
        int        len;
        int        note;
        int        step;
    } seg_t;

    seg_t segq[$];
    int   seg_off = 0;
    int   m_step  = 0;
    int   m_song  = 0;

    // Expand a song into the sequence of phases it must pass through.
    task automatic build_song(input int song);
        segq.delete();
        for (int s = 0; s < 16; s++) begin
            int code;
            int dur;
            code = int'(rom[song * 16 + s][7:3]);
            dur  = int'(rom[song * 16 + s][2:0]);
            segq.push_back('{SkLoad, 1, 0, s});
            if (code == 31) begin
                segq.push_back('{SkDone, 1, 0, s});
                return;
            end
            segq.push_back('{SkPlay, (dur + 1) * Beat, code, s});
            segq.push_back('{SkGap, Gap, 0, s});
            segq.push_back('{SkAdv, 1, 0, s});
        end
        segq.push_back('{SkDone, 1, 0, 15});
    endtask

    // Compare the main DUT against the model every cycle, then step the model.
    always @(negedge clk) begin
        logic e_tone;
        logic e_busy;
        logic e_done;
        logic [12:0] exp_v;
        logic [12:0] act_v;
        if (!rst_n) begin
            segq.delete();
            seg_off = 0;
            m_step  = 0;
            m_song  = 0;
        end
        e_tone = 1'b0;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (segq.size() > 0) begin
            m_step = segq[0].step;
            case (segq[0].kind)
                SkLoad, SkGap, SkAdv: e_busy = 1'b1;
                SkPlay: begin
                    e_busy = 1'b1;
                    if (segq[0].note >= 1 && segq[0].note <= 24)
                        e_tone = ((seg_off / half_model(segq[0].note)) % 2) == 1;
                end
                default: e_done = 1'b1;
            endcase
        end
        exp_v = {e_tone, e_busy, e_done, 4'(m_step), 2'(m_song), 4'(m_step)};
        act_v = {m_if.tone, m_if.busy, m_if.done, m_if.step, m_if.rom_addr};
        check("cycle_model{tone,busy,done,step,addr}", act_v, exp_v);
        if (rst_n) begin
            if (m_if.stop) begin
                segq.delete();
                seg_off = 0;
            end else if (segq.size() == 0) begin
                if (m_if.start) begin
                    m_song = int'(m_if.song_sel);
                    m_step = 0;
                    build_song(m_song);
                    seg_off = 0;
                end
            end else begin
                seg_off++;
                if (seg_off >= segq[0].len) begin
                    void'(segq.pop_front());
                    seg_off = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_if.done) m_done_cnt++;
        if (l_if.done) l_done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic [1:0] song);
        @(posedge clk); #1;
        m_if.song_sel = song;
        m_if.start    = 1'b1;
        @(posedge clk); #1;
        m_if.start    = 1'b0;
    endtask

    // Called right after pulse_start: the next negedge is one cycle after start.
    task automatic run_to_done(input int budget, input logic [1:0] song, output int off,
                               output int toggles, output int first_rise,
                               output int rise_step, output int bad_song);
        logic prev;
        prev       = 1'b0;
        toggles    = 0;
        first_rise = -1;
        rise_step  = -1;
        bad_song   = 0;
        off        = 1;
        forever begin
            @(negedge clk);
            if (m_if.tone != prev) begin
                toggles++;
                if (m_if.tone && first_rise < 0) begin
                    first_rise = off;
                    rise_step  = int'(m_if.step);
                end
            end
            prev = m_if.tone;
            if (m_if.busy && m_if.rom_addr[5:4] != song) bad_song++;
            if (m_if.done) return;
            off++;
            if (off > budget) begin
                timeout_fail("run_to_done");
                return;
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int off;
        int tg;
        int fr;
        int rs;
        int bad;
        int d0;
        bit ok;

        for (int i = 0; i < 64; i++) rom[i] = {5'd31, 3'd0};
        // song 0: A4 for one beat
        rom[0]  = {5'd10, 3'd0};
        // song 1: 4-beat rest, then C4
        rom[16] = {5'd0, 3'd3};
        rom[17] = {5'd1, 3'd0};
        // song 2: five notes then END
        rom[32] = {5'd12, 3'd0};
        rom[33] = {5'd14, 3'd0};
        rom[34] = {5'd15, 3'd0};
        rom[35] = {5'd17, 3'd0};
        rom[36] = {5'd19, 3'd0};
        // song 3: 16 entries, no END; includes a plain rest and a code-27 rest
        for (int s = 0; s < 16; s++) rom[48 + s] = {5'(s + 9), 3'd0};
        rom[48 + 4] = {5'd27, 3'd0};
        rom[48 + 7] = {5'd16, 3'd1};
        rom[48 + 9] = {5'd0, 3'd0};

        m_if.start = 1'b0; m_if.stop = 1'b0; m_if.song_sel = 2'd0;
        l_if.start = 1'b0; l_if.stop = 1'b0; l_if.song_sel = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tone", m_if.tone, 0);
        check("reset_busy", m_if.busy, 0);
        check("reset_done", m_if.done, 0);
        check("reset_step", m_if.step, 0);
        check("reset_rom_addr", m_if.rom_addr, 0);
        rst_n = 1'b1;

        check("half_a4", half_model(10), 100);
        check("half_c4", half_model(1), 168);

        // Single A4 note
        d0 = m_done_cnt;
        pulse_start(2'd0);
        run_to_done(2000, 2'd0, off, tg, fr, rs, bad);
        check("single_done_time", off, 1006);
        check("single_toggles", tg, 10);
        check("single_first_rise", fr, 102);
        check("single_busy_at_done", m_if.busy, 0);
        repeat (4) @(negedge clk);
        check("single_done_count", m_done_cnt - d0, 1);

        // Rest then C4
        d0 = m_done_cnt;
        pulse_start(2'd1);
        run_to_done(7000, 2'd1, off, tg, fr, rs, bad);
        check("rest_done_time", off, 5010);
        check("rest_first_rise", fr, 4174);
        check("rest_step_at_rise", rs, 1);
        check("rest_toggles", tg, 6);
        check("rest_step_at_done", m_if.step, 2);
        repeat (4) @(negedge clk);
        check("rest_done_count", m_done_cnt - d0, 1);

        // Full 16-step song, no END marker
        d0 = m_done_cnt;
        pulse_start(2'd3);
        run_to_done(18000, 2'd3, off, tg, fr, rs, bad);
        check("full_done_time", off, 17065);
        check("full_step_at_done", m_if.step, 15);
        repeat (5) @(negedge clk);
        check("full_idle_busy", m_if.busy, 0);
        check("full_done_count", m_done_cnt - d0, 1);

        // Same song on the looping instance: wraps to step 0, never done
        @(posedge clk); #1;
        l_if.song_sel = 2'd3;
        l_if.start    = 1'b1;
        @(posedge clk); #1;
        l_if.start    = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (l_if.step == 4'd15) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("loop_reach_step15");
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (l_if.step == 4'd0) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("loop_wrap_step0");
        check("loop_busy_after_wrap", l_if.busy, 1);
        check("loop_done_count", l_done_cnt, 0);
        @(posedge clk); #1;
        l_if.stop = 1'b1;
        @(posedge clk); #1;
        l_if.stop = 1'b0;
        @(negedge clk);
        check("loop_stop_busy", l_if.busy, 0);

        // Stop 500 cycles into the A4 note
        d0 = m_done_cnt;
        pulse_start(2'd0);
        repeat (501) @(posedge clk);
        #1;
        check("stop_tone_before", m_if.tone, 1);
        m_if.stop = 1'b1;
        @(posedge clk); #1;
        m_if.stop = 1'b0;
        check("stop_tone_after", m_if.tone, 0);
        check("stop_busy_after", m_if.busy, 0);
        check("stop_step_after", m_if.step, 0);
        repeat (10) @(negedge clk);
        check("stop_no_done", m_done_cnt - d0, 0);

        // Start while busy with another song_sel is ignored
        d0 = m_done_cnt;
        pulse_start(2'd2);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (m_if.step == 4'd3) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("sel_reach_step3");
        pulse_start(2'd1);
        run_to_done(6000, 2'd2, off, tg, fr, rs, bad);
        check("sel_song_bits_stray", bad, 0);
        check("sel_step_at_done", m_if.step, 5);
        check("sel_rom_addr_song", m_if.rom_addr[5:4], 2);
        repeat (4) @(negedge clk);
        check("sel_done_count", m_done_cnt - d0, 1);

        // Async reset mid-note while tone is high
        pulse_start(2'd3);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (m_if.step == 4'd2 && m_if.tone) begin ok = 1'b1; break; end
        end
        if (!ok) timeout_fail("reset_reach_tone");
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_tone", m_if.tone, 0);
        check("areset_busy", m_if.busy, 0);
        check("areset_step", m_if.step, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("areset_stays_idle", m_if.busy, 0);
        check("areset_step_idle", m_if.step, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/melody_seq.md
Name: melody_seq

Overview:
- Melody sequencer that feeds one tone line into the level selector. Each game level instantiates one melody_seq.
- Steps through up to 16 note words of a selected song in an external asynchronous note ROM, holding each note for a programmable number of beats.
- Generates the square-wave tone for each note and inserts a short silent gap between notes.
- Reports busy, the current step, and a one-cycle done pulse at song end.

Parameters:
- CLK_HZ, 50000000, clk frequency in Hz; used to derive the note half-period table.
- BEAT_CYCLES, 6250000, clk cycles per beat unit.
- GAP_CYCLES, 250000, silent clk cycles after every note; 0 means no gap.
- LOOP, 0, 1 restarts the song at step 0 instead of finishing.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin the song; acted on only in IDLE.
- stop  in  1  abort immediately; takes priority over start.
- song_sel  in  2  song number; sampled on an accepted start.
- rom_addr  out  6  {song_q, step}.
- rom_data  in  8  [7:3] note code, [2:0] duration code; read combinationally, valid in the same cycle as rom_addr.
- tone  out  1  square-wave audio output.
- busy  out  1  high from LOAD through GAP.
- step  out  4  current step index.
- done  out  1  one-cycle pulse at natural song end.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; tone=0, busy=0, done=0, step=0, rom_addr=0.
  - All counters cleared.
- Note codes:
  - 0 = rest.
  - 1..24 = C4..B5, with f(n)=440*2^((n-10)/12), so n=10 is A4.
  - 25..30 = treated as rest.
  - 31 = END marker.
- Half-period table: HALF(n)=round(CLK_HZ/(2*f(n))), minimum 1, fixed at elaboration. Example: CLK_HZ=50e6 gives A4 = 56818.
- Duration: note length is (dur+1)*BEAT_CYCLES cycles, giving 1..8 beats.
- States:
  - IDLE:
    - tone=0, busy=0.
    - start=1 and stop=0: latch song_sel into song_q, step=0, go to LOAD next cycle.
  - LOAD (1 cycle):
    - Samples rom_data.
    - Note code 31: go to DONE.
    - Otherwise: latch note and dur, clear the half-period and beat counters, tone=0, go to PLAY.
  - PLAY:
    - Lasts exactly (dur+1)*BEAT_CYCLES cycles.
    - For a pitched note, tone toggles every HALF(note) cycles; the first toggle occurs HALF cycles after PLAY entry.
    - For a rest, tone stays 0.
    - Exit: go to GAP, or straight to ADV if GAP_CYCLES=0.
  - GAP:
    - tone=0 for GAP_CYCLES cycles, then go to ADV.
  - ADV (1 cycle):
    - step<15: step+1, go to LOAD.
    - step=15 and LOOP=1: step=0, go to LOAD.
    - step=15 and LOOP=0: go to DONE.
  - DONE (1 cycle):
    - done=1, busy=0, tone=0, step holds its last value.
    - Next cycle: IDLE.
- stop=1 in any state:
  - Next cycle: IDLE, tone=0, busy=0.
  - step is left as is; no done pulse.
- start while busy is ignored. song_sel changes while busy are ignored.
- tone is a registered output, glitch-free.

Test Plan:
- Parameter set for all scenarios: CLK_HZ=88000 (HALF: A4=100, C4=168), BEAT_CYCLES=1000, GAP_CYCLES=2, LOOP=0.
- Single note: ROM song0 = {A4, dur0}, then END; pulse start.
  - tone toggles every 100 cycles for 1000 cycles (10 toggles), then 0 for 2 cycles.
  - done pulses exactly once; busy falls with done.
  - Total time from start to done: 1+1000+2+1+1+1 cycles.
- Rest and duration: ROM entries {rest, dur3}, {C4, dur0}.
  - tone stays 0 for 4000 cycles.
  - Then toggles every 168 cycles for 1000 cycles.
  - step goes 0 then 1.
- Full song without END: 16 notes.
  - After step 15, done pulses once and the block returns to IDLE.
  - With LOOP=1, step wraps to 0 and done never pulses.
- Stop mid-note: assert stop 500 cycles into PLAY of A4.
  - Next cycle: tone=0, busy=0.
  - done stays 0; step is unchanged.
- Start while busy, and song select: pulse start with song_sel=2 at step 3, then pulse start again with song_sel=1.
  - Playback is unaffected by the second start; rom_addr[5:4] stays 2.
- Async reset: drop rst_n mid-PLAY with tone=1.
  - tone, busy and step go to 0 immediately.
  - After rst_n=1, the block stays IDLE until the next start.
